fft_seq_ctrl: RTL and testbench

//  Sequencer and address generator for an in-place radix-2 DIT FFT engine (default 32 points).

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_agu.sv | 63 ++++++
 rtl/fft_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT sequencer: default sizes,
// FSM state encodings and a width helper for parameterised counters.
package fft_pkg;

    localparam int LOG2N_DEF = 5;
    localparam int LAT_DEF   = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/fft_agu.sv
// Address generation unit: stage/butterfly counters and the in-place
// radix-2 DIT address arithmetic (top/bottom read address, twiddle index).
module fft_agu
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [LOG2N-1:0] o_addr_a,
    output logic [LOG2N-1:0] o_addr_b,
    output logic [LOG2N-2:0] o_addr_tw,
    output logic             o_last_bfly,
    output logic             o_last_stage
);

    localparam int SW = cnt_width(LOG2N);

    logic [SW-1:0]    r_stage;
    logic [LOG2N-2:0] r_bfly;

    logic [LOG2N-2:0] w_mask;
    logic [LOG2N-2:0] w_pos;
    logic [LOG2N-2:0] w_grp;
    logic [LOG2N-1:0] w_half;
    logic [LOG2N-1:0] w_addr_a;

    assign o_last_bfly  = (r_bfly == {(LOG2N-1){1'b1}});
    assign o_last_stage = (r_stage == SW'(LOG2N-1));

    // Stage/butterfly counters; clear has priority, stage wraps after the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage <= '0;
            r_bfly  <= '0;
        end else if (i_rst) begin
            r_stage <= '0;
            r_bfly  <= '0;
        end else if (i_en) begin
            if (o_last_bfly) begin
                r_bfly  <= '0;
                r_stage <= o_last_stage ? SW'(0) : (r_stage + SW'(1));
            end else begin
                r_bfly  <= r_bfly + (LOG2N-1)'(1);
            end
        end
    end

    // Butterfly geometry: pos within group, group index, span (half) and addresses.
    always_comb begin
        w_half    = {{(LOG2N-1){1'b0}}, 1'b1} << r_stage;
        w_mask    = ~({(LOG2N-1){1'b1}} << r_stage);
        w_pos     = r_bfly & w_mask;
        w_grp     = r_bfly >> r_stage;
        w_addr_a  = (({1'b0, w_grp} << r_stage) << 1'b1) | {1'b0, w_pos};
        o_addr_a  = w_addr_a;
        o_addr_b  = w_addr_a + w_half;
        o_addr_tw = w_pos << (SW'(LOG2N-1) - r_stage);
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// FFT sequencer: IDLE/RUN/DRAIN/DONE control, drain counter that keeps each
// stage's last write ahead of the next stage's first read, write-back delay
// lines matching the butterfly latency, and the ping-pong bank select.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             work,
    output logic             rst_addr,
    output logic             inc_addr,
    output logic [LOG2N-1:0] addr_A,
    output logic [LOG2N-1:0] addr_B,
    output logic [LOG2N-2:0] addr_Tw,
    output logic             WRmem,
    output logic [LOG2N-1:0] wr_addr_A,
    output logic [LOG2N-1:0] wr_addr_B,
    output logic             rst_swap,
    output logic             en_swap,
    output logic             bank_sel,
    output logic             done
);

    localparam int DW = cnt_width(LAT);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [DW-1:0]    r_dcnt;
    logic             r_drain_last;
    logic             r_bank;
    logic             r_inc_dly [0:LAT-1];
    logic [LOG2N-1:0] r_a_dly   [0:LAT-1];
    logic [LOG2N-1:0] r_b_dly   [0:LAT-1];

    logic             w_last_bfly;
    logic             w_last_stage;
    logic             w_drain_end;

    assign work      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign rst_addr  = (r_state == ST_IDLE);
    assign inc_addr  = (r_state == ST_RUN);
    assign rst_swap  = (r_state == ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign w_drain_end = (r_state == ST_DRAIN) && (r_dcnt == DW'(LAT-1));
    assign en_swap   = w_drain_end;
    assign bank_sel  = r_bank;
    assign WRmem     = r_inc_dly[LAT-1];
    assign wr_addr_A = r_a_dly[LAT-1];
    assign wr_addr_B = r_b_dly[LAT-1];

    fft_agu #(
        .LOG2N (LOG2N)
    ) u_agu (
        .clk          (clk),
        .reset        (reset),
        .i_rst        (rst_addr),
        .i_en         (inc_addr),
        .o_addr_a     (addr_A),
        .o_addr_b     (addr_B),
        .o_addr_tw    (addr_Tw),
        .o_last_bfly  (w_last_bfly),
        .o_last_stage (w_last_stage)
    );

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last_bfly) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_end) begin
                    w_state_nxt = r_drain_last ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain cycle counter; runs only while draining and restarts each stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dcnt <= '0;
        end else if ((r_state == ST_DRAIN) && !w_drain_end) begin
            r_dcnt <= r_dcnt + DW'(1);
        end else begin
            r_dcnt <= '0;
        end
    end

    // Remember whether the stage being drained was the final one (the AGU has already wrapped).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drain_last <= 1'b0;
        end else if ((r_state == ST_RUN) && w_last_bfly) begin
            r_drain_last <= w_last_stage;
        end
    end

    // Write-back delay lines, shifted every cycle so writes trail reads by LAT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                r_inc_dly[i] <= 1'b0;
                r_a_dly[i]   <= '0;
                r_b_dly[i]   <= '0;
            end
        end else begin
            r_inc_dly[0] <= inc_addr;
            r_a_dly[0]   <= addr_A;
            r_b_dly[0]   <= addr_B;
            for (int i = 1; i < LAT; i++) begin
                r_inc_dly[i] <= r_inc_dly[i-1];
                r_a_dly[i]   <= r_a_dly[i-1];
                r_b_dly[i]   <= r_b_dly[i-1];
            end
        end
    end

    // Ping-pong bank select: cleared while idle, flipped at the end of each stage drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bank <= 1'b0;
        end else if (rst_swap) begin
            r_bank <= 1'b0;
        end else if (en_swap) begin
            r_bank <= ~r_bank;
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: a run-cycle-indexed model of the
// FFT schedule predicts every output each cycle; random start levels and a
// mid-run reset exercise the control flow.
module tb_fft_seq_ctrl;

    localparam int LOG2N  = 5;
    localparam int LAT    = 3;
    localparam int NB     = 16;
    localparam int WIN    = NB + LAT;
    localparam int DONE_C = LOG2N * WIN;
    localparam int NCYC   = 900;

    logic       clk;
    logic       reset;
    logic       start;
    logic       work, rst_addr, inc_addr, WRmem, rst_swap, en_swap, bank_sel, done;
    logic [4:0] addr_A, addr_B, wr_addr_A, wr_addr_B;
    logic [3:0] addr_Tw;

    fft_seq_ctrl #(.LOG2N(LOG2N), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .work      (work),
        .rst_addr  (rst_addr),
        .inc_addr  (inc_addr),
        .addr_A    (addr_A),
        .addr_B    (addr_B),
        .addr_Tw   (addr_Tw),
        .WRmem     (WRmem),
        .wr_addr_A (wr_addr_A),
        .wr_addr_B (wr_addr_B),
        .rst_swap  (rst_swap),
        .en_swap   (en_swap),
        .bank_sel  (bank_sel),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model state
    bit m_run;
    int m_c;
    bit m_bank;
    int h_inc [3];
    int h_a   [3];
    int h_b   [3];

    // expected values for the current cycle
    int e_work, e_rst, e_inc, e_a, e_b, e_tw, e_swap, e_done;
    int st, k, s, b, half;

    bit [31:0] smask;
    int  swaps;
    int  runs;
    bit  did_mid;
    bit  nreset, nstart;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        m_run = 1'b0; m_c = 0; m_bank = 1'b0;
        for (int i = 0; i < 3; i++) begin h_inc[i] = 0; h_a[i] = 0; h_b[i] = 0; end
        smask = '0; swaps = 0; runs = 0; did_mid = 1'b0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);

            // ---- model outputs for this cycle ----
            e_work = 0; e_rst = 0; e_inc = 0; e_swap = 0; e_done = 0;
            s = 0; b = 0; k = 0;
            if (!m_run) begin
                e_rst = 1;
            end else if (m_c == DONE_C) begin
                e_done = 1;
            end else begin
                st = m_c / WIN;
                k  = m_c % WIN;
                e_work = 1;
                if (k < NB) begin
                    e_inc = 1; s = st; b = k;
                end else begin
                    s = (st + 1) % LOG2N;
                    e_swap = (k == WIN - 1) ? 1 : 0;
                end
            end
            half = 1 << s;
            e_a  = (b / half) * 2 * half + (b % half);
            e_b  = e_a + half;
            e_tw = (b % half) * (NB / half);

            // ---- per-cycle comparison ----
            chk("work",      work,      e_work);
            chk("rst_addr",  rst_addr,  e_rst);
            chk("rst_swap",  rst_swap,  e_rst);
            chk("inc_addr",  inc_addr,  e_inc);
            chk("addr_A",    addr_A,    e_a);
            chk("addr_B",    addr_B,    e_b);
            chk("addr_Tw",   addr_Tw,   e_tw);
            chk("WRmem",     WRmem,     h_inc[2]);
            chk("wr_addr_A", wr_addr_A, h_a[2]);
            chk("wr_addr_B", wr_addr_B, h_b[2]);
            chk("en_swap",   en_swap,   e_swap);
            chk("bank_sel",  bank_sel,  m_bank);
            chk("done",      done,      e_done);

            // ---- hand-computed pins ----
            if (m_run) begin
                if (m_c == 3) begin
                    chk("pin_s0b3_A", addr_A, 6); chk("pin_s0b3_B", addr_B, 7); chk("pin_s0b3_Tw", addr_Tw, 0);
                end else if (m_c == 43) begin
                    chk("pin_s2b5_A", addr_A, 9); chk("pin_s2b5_B", addr_B, 13); chk("pin_s2b5_Tw", addr_Tw, 4);
                end else if (m_c == 91) begin
                    chk("pin_s4b15_A", addr_A, 15); chk("pin_s4b15_B", addr_B, 31); chk("pin_s4b15_Tw", addr_Tw, 15);
                end else if (m_c == 18) begin
                    chk("pin_drain_inc", inc_addr, 0); chk("pin_swap18", en_swap, 1);
                end else if (m_c == 19) begin
                    chk("pin_bank19", bank_sel, 1);
                end else if (m_c == 95) begin
                    chk("pin_done95", done, 1);
                end
            end

            // ---- per-stage uniqueness / coverage, per-run swap count ----
            if (m_run && m_c == 0) swaps = 0;
            if (m_run && en_swap === 1'b1) swaps++;
            if (m_run && m_c < DONE_C && k < NB) begin
                if (k == 0) smask = '0;
                chk("a_unique", {31'd0, smask[addr_A]}, 0);
                smask[addr_A] = 1'b1;
                chk("b_unique", {31'd0, smask[addr_B]}, 0);
                smask[addr_B] = 1'b1;
                if (k == NB - 1) chk("stage_cover", smask, 32'hFFFF_FFFF);
            end
            if (m_run && m_c == DONE_C) begin
                chk("swaps_per_run", swaps, LOG2N);
                runs++;
            end

            // ---- next-cycle stimulus ----
            nreset = 1'b0;
            if (cyc < 3) begin
                nreset = 1'b1;
            end else if (!did_mid && cyc > 260 && m_run && m_c == 40) begin
                nreset = 1'b1;
                did_mid = 1'b1;
            end
            if (cyc < 5)        nstart = 1'b0;
            else if (cyc < 260) nstart = 1'b1;
            else                nstart = ($urandom_range(0, 1) == 1);
            start = nstart;

            if (nreset && !reset) begin
                reset = 1'b1;
                #1;
                chk("midrst_work",  work,     0);
                chk("midrst_inc",   inc_addr, 0);
                chk("midrst_wr",    WRmem,    0);
                chk("midrst_swap",  en_swap,  0);
                chk("midrst_bank",  bank_sel, 0);
                chk("midrst_done",  done,     0);
                chk("midrst_A",     addr_A,   0);
            end
            reset = nreset;

            // ---- advance model ----
            if (nreset) begin
                m_run = 1'b0; m_c = 0; m_bank = 1'b0;
                for (int i = 0; i < 3; i++) begin h_inc[i] = 0; h_a[i] = 0; h_b[i] = 0; end
            end else begin
                h_inc[2] = h_inc[1]; h_inc[1] = h_inc[0]; h_inc[0] = e_inc;
                h_a[2]   = h_a[1];   h_a[1]   = h_a[0];   h_a[0]   = e_a;
                h_b[2]   = h_b[1];   h_b[1]   = h_b[0];   h_b[0]   = e_b;
                if (!m_run)         m_bank = 1'b0;
                else if (e_swap==1) m_bank = ~m_bank;
                if (!m_run) begin
                    if (nstart) begin m_run = 1'b1; m_c = 0; end
                end else if (m_c == DONE_C) begin
                    m_run = 1'b0;
                end else begin
                    m_c++;
                end
            end
        end

        chk("runs_completed_ge3", {31'd0, (runs >= 3)}, 1);
        chk("mid_reset_hit", {31'd0, did_mid}, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
